fell_event_sched: RTL

- Monitors N single-bit status lines and detects a falling edge (1 in the previous sample, 0 in the current one) on each, in the same sense as the sampled-value fell check used in our assertion benches.
- Queues one pending event per line, with a timestamp.
- Round-robin shares a single valid/ready event channel among the N lines. This channel feeds the logging/monitor path.
- Gives the bench and assertion layer one ordered stream of fall events instead of N independent checkers.

---
 rtl/fell_sched_pkg.sv | 16 +
 rtl/fell_sched_rr_pick.sv | 30 +++
 rtl/fell_event_sched.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/fell_sched_pkg.sv
// Shared types and constants for the falling-edge event scheduler.
package fell_sched_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_e;

  localparam int TS_W_DEF   = 16;
  localparam int DROP_W_DEF = 8;

  function automatic int chan_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fell_sched_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module fell_sched_rr_pick
  import fell_sched_pkg::*;
#(
  parameter int N  = 4,
  parameter int CW = chan_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [CW-1:0] ptr_i,
  output logic          gnt_valid_o,
  output logic [CW-1:0] gnt_idx_o
);

  // Walk from the farthest candidate back to ptr so the closest request wins.
  always_comb begin
    int sum;
    int idx;
    gnt_valid_o = 1'b0;
    gnt_idx_o   = '0;
    sum         = 0;
    idx         = 0;
    for (int k = N - 1; k >= 0; k--) begin
      sum         = int'(ptr_i) + k;
      idx         = (sum >= N) ? (sum - N) : sum;
      gnt_valid_o = gnt_valid_o | req_i[idx];
      gnt_idx_o   = req_i[idx] ? CW'(idx) : gnt_idx_o;
    end
  end

endmodule

// File: rtl/fell_event_sched.sv
// Falling-edge detector with per-line pending events, round-robin onto one valid/ready channel.
// Optional dropped-event counter enabled by defining FELL_SCHED_DROP_CNT_EN.
module fell_event_sched
  import fell_sched_pkg::*;
#(
  parameter int N    = 4,
  parameter int TS_W = TS_W_DEF
`ifdef FELL_SCHED_DROP_CNT_EN
  , parameter int DROP_W = DROP_W_DEF
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable_i,
  input  logic [N-1:0]          sig_i,
  output logic                  evt_valid_o,
  input  logic                  evt_ready_i,
  output logic [chan_w(N)-1:0]  evt_chan_o,
  output logic [TS_W-1:0]       evt_ts_o,
  output logic [N-1:0]          pend_o
`ifdef FELL_SCHED_DROP_CNT_EN
  , output logic [DROP_W-1:0]   drop_cnt_o
`endif
);

  localparam int CW = chan_w(N);

  state_e            state_q, state_d;
  logic [N-1:0]      sig_q, sig_d;
  logic [TS_W-1:0]   ts_q, ts_d;
  logic [N-1:0]      pend_q, pend_d;
  logic [TS_W-1:0]   ts_store_q [N];
  logic [TS_W-1:0]   ts_store_d [N];
  logic [CW-1:0]     ptr_q, ptr_d;
  logic              valid_q, valid_d;
  logic [CW-1:0]     chan_q, chan_d;
  logic [TS_W-1:0]   evt_ts_q, evt_ts_d;

  logic [N-1:0]      fall;
  logic              hs;
  logic [N-1:0]      hs_vec;
  logic [CW-1:0]     ptr_hs;
  logic [N-1:0]      pick_req;
  logic [CW-1:0]     pick_ptr;
  logic              gnt_valid;
  logic [CW-1:0]     gnt_idx;

  // Edge detection, timestamp counter and per-line capture bookkeeping.
  always_comb begin
    sig_d  = sig_i;
    ts_d   = ts_q + TS_W'(1);
    fall   = sig_q & ~sig_i & {N{enable_i}};
    hs     = (state_q == OFFER) & evt_ready_i;
    ptr_hs = (chan_q == CW'(N - 1)) ? CW'(0) : (chan_q + CW'(1));
    pend_d = pend_q;
    hs_vec = '0;
    for (int i = 0; i < N; i++) begin
      ts_store_d[i] = ts_store_q[i];
      hs_vec[i]     = hs & (chan_q == CW'(i));
      if (hs_vec[i]) begin
        // A fall on the edge the line is being served restarts its event.
        pend_d[i] = fall[i];
        if (fall[i]) begin
          ts_store_d[i] = ts_q;
        end else begin
          ts_store_d[i] = ts_store_q[i];
        end
      end else if (fall[i] & ~pend_q[i]) begin
        pend_d[i]     = 1'b1;
        ts_store_d[i] = ts_q;
      end else begin
        pend_d[i]     = pend_q[i];
        ts_store_d[i] = ts_store_q[i];
      end
    end
    pick_req = (state_q == OFFER) ? pend_d : pend_q;
    pick_ptr = (state_q == OFFER) ? ptr_hs : ptr_q;
  end

  fell_sched_rr_pick #(
    .N  (N),
    .CW (CW)
  ) u_pick (
    .req_i       (pick_req),
    .ptr_i       (pick_ptr),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx)
  );

  // Channel FSM next-state: load on pick, hold while stalled, re-pick after a handshake.
  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    chan_d   = chan_q;
    evt_ts_d = evt_ts_q;
    ptr_d    = ptr_q;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          state_d  = OFFER;
          valid_d  = 1'b1;
          chan_d   = gnt_idx;
          evt_ts_d = ts_store_q[gnt_idx];
        end else begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      end
      OFFER: begin
        if (hs) begin
          ptr_d = ptr_hs;
          if (gnt_valid) begin
            state_d  = OFFER;
            valid_d  = 1'b1;
            chan_d   = gnt_idx;
            evt_ts_d = ts_store_d[gnt_idx];
          end else begin
            state_d = IDLE;
            valid_d = 1'b0;
          end
        end else begin
          state_d = OFFER;
          valid_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // All scheduler state, with registered channel outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sig_q    <= '0;
      ts_q     <= '0;
      pend_q   <= '0;
      ptr_q    <= '0;
      valid_q  <= 1'b0;
      chan_q   <= '0;
      evt_ts_q <= '0;
      for (int i = 0; i < N; i++) begin
        ts_store_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      sig_q    <= sig_d;
      ts_q     <= ts_d;
      pend_q   <= pend_d;
      ptr_q    <= ptr_d;
      valid_q  <= valid_d;
      chan_q   <= chan_d;
      evt_ts_q <= evt_ts_d;
      for (int i = 0; i < N; i++) begin
        ts_store_q[i] <= ts_store_d[i];
      end
    end
  end

  assign evt_valid_o = valid_q;
  assign evt_chan_o  = chan_q;
  assign evt_ts_o    = evt_ts_q;
  assign pend_o      = pend_q;

`ifdef FELL_SCHED_DROP_CNT_EN
  localparam int DN_W = $clog2(N + 1);

  logic [N-1:0]      drop;
  logic [DN_W-1:0]   drop_num;
  logic [DROP_W:0]   drop_sum;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  // Count lines re-falling while still pending and not being served, saturating.
  always_comb begin
    drop     = fall & pend_q & ~hs_vec;
    drop_num = '0;
    for (int i = 0; i < N; i++) begin
      drop_num = drop_num + DN_W'(drop[i]);
    end
    drop_sum   = {1'b0, drop_cnt_q} + (DROP_W + 1)'(drop_num);
    drop_cnt_d = drop_sum[DROP_W] ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
  end

  // Dropped-event counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt_o = drop_cnt_q;
`endif

endmodule
